// File: rtl/key_cond_if.sv
// key_cond_if: bundles the raw board inputs (buttons, switch bank) and the
// conditioned outputs that feed the up/down counter.
// master = the board or bench side, slave = the conditioner itself.
interface key_cond_if #(
    parameter int SW_W = 4
);
    logic            btn_set;
    logic            btn_dec;
    logic [SW_W-1:0] sw;
    logic            set;
    logic [SW_W-1:0] set_count;
    logic            dec;

    modport master (
        output btn_set, btn_dec, sw,
        input  set, set_count, dec
    );

    modport slave (
        input  btn_set, btn_dec, sw,
        output set, set_count, dec
    );
endinterface

// File: rtl/key_cond.sv
// key_cond: input conditioner for the 4-bit up/down counter.
// - Synchronises two raw push-buttons and a switch bank through two flops.
// - Debounces each button.
// - Turns a btn_set press into a one-cycle set pulse that carries a latched
//   set_count, and toggles the dec level on each btn_dec press.
// Optional build macro KEY_COND_AUTO_REPEAT_EN: while btn_set is held, a
// further set pulse is emitted every REPEAT_CYCLES cycles after the first.
module key_cond #(
    parameter int DEB_CYCLES = 4,
    parameter int SW_W       = 4
`ifdef KEY_COND_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    key_cond_if.slave  bus
);

    localparam int IDX_SET = 0;
    localparam int IDX_DEC = 1;
    localparam int CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    // Button synchronisers. Bit 0 is btn_set and bit 1 is btn_dec.
    logic [1:0]      btn_s1_q, btn_s1_d;
    logic [1:0]      btn_s2_q, btn_s2_d;
    logic [SW_W-1:0] sw_s1_q, sw_s1_d;
    logic [SW_W-1:0] sw_s2_q, sw_s2_d;

    // Debounce state: the run-length counter, the debounced level, and a
    // one-cycle-delayed copy of the level used for press detection.
    logic [CNT_W-1:0] deb_cnt_q [2];
    logic [CNT_W-1:0] deb_cnt_d [2];
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       deb_dly_q, deb_dly_d;

    // Registered outputs.
    logic            set_q, set_d;
    logic [SW_W-1:0] set_count_q, set_count_d;
    logic            dec_q, dec_d;

    logic [1:0] press;
    logic       fire_set;

`ifdef KEY_COND_AUTO_REPEAT_EN
    localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

    // Next-state logic for synchronisers, debouncers, press detection and outputs.
    // NOTE: every combinational output gets a default at the top of the block,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        btn_s1_d = {bus.btn_dec, bus.btn_set};
        btn_s2_d = btn_s1_q;
        sw_s1_d  = bus.sw;
        sw_s2_d  = sw_s1_q;

        for (int i = 0; i < 2; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = '0;
            if (btn_s2_q[i] != deb_q[i]) begin
                // The level flips only after the input has disagreed with it
                // for DEB_CYCLES consecutive samples. Any agreement before
                // then clears the count through the default above.
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
                end
            end
        end

        deb_dly_d = deb_q;
        press     = deb_q & ~deb_dly_q;
        fire_set  = press[IDX_SET];

`ifdef KEY_COND_AUTO_REPEAT_EN
        // The repeat timer restarts on the initial press and runs only while
        // the debounced button is held, so it clears on release.
        rpt_cnt_d = '0;
        if (!press[IDX_SET] && deb_q[IDX_SET]) begin
            if (rpt_cnt_q == RPT_LAST) begin
                fire_set = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end
`endif

        set_d       = fire_set;
        set_count_d = fire_set ? sw_s2_q : set_count_q;
        dec_d       = dec_q ^ press[IDX_DEC];
    end

    // State registers with synchronous active-high reset that overrides everything.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1_q    <= '0;
            btn_s2_q    <= '0;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
            end
            deb_q       <= '0;
            deb_dly_q   <= '0;
            set_q       <= 1'b0;
            set_count_q <= '0;
            dec_q       <= 1'b0;
`ifdef KEY_COND_AUTO_REPEAT_EN
            rpt_cnt_q   <= '0;
`endif
        end else begin
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
            sw_s1_q     <= sw_s1_d;
            sw_s2_q     <= sw_s2_d;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            deb_q       <= deb_d;
            deb_dly_q   <= deb_dly_d;
            set_q       <= set_d;
            set_count_q <= set_count_d;
            dec_q       <= dec_d;
`ifdef KEY_COND_AUTO_REPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
`endif
        end
    end

    assign bus.set       = set_q;
    assign bus.set_count = set_count_q;
    assign bus.dec       = dec_q;

endmodule

// File: tb/tb_key_cond.sv
// tb_key_cond: directed testbench for key_cond with DEB_CYCLES=4 and SW_W=4.
// Notation: cycle index c=0 is the first rising edge at which a new input
// value is sampled. Outputs are observed 1 ns after each rising edge.
module tb_key_cond;

    localparam int RPT = 32;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    key_cond_if #(.SW_W(4)) bus ();

    key_cond #(.DEB_CYCLES(4), .SW_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before observing or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected set value at cycle c of a held btn_set press.
    function automatic logic exp_pulse(int c);
`ifdef KEY_COND_AUTO_REPEAT_EN
        return (c >= 6) && (((c - 6) % RPT) == 0);
`else
        return c == 6;
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if ({bus.set, bus.dec, bus.set_count} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_state got set=%b dec=%b cnt=%h want 0/0/0", bus.set, bus.dec, bus.set_count);
        end
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            n_cmp++;
            if ({bus.set, bus.dec, bus.set_count} !== 6'b0) begin
                n_err++;
                $display("FAIL reset_idle c=%0d got set=%b dec=%b cnt=%h want 0/0/0", c, bus.set, bus.dec, bus.set_count);
            end
        end
    endtask

    task automatic test_set_press();
        bus.sw      = 4'b1010;
        bus.btn_set = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            n_cmp++;
            if (bus.set !== exp_pulse(c)) begin
                n_err++;
                $display("FAIL set_press_set c=%0d got %b want %b", c, bus.set, exp_pulse(c));
            end
            n_cmp++;
            if (bus.set_count !== ((c >= 6) ? 4'b1010 : 4'b0000)) begin
                n_err++;
                $display("FAIL set_press_cnt c=%0d got %h want %h", c, bus.set_count, (c >= 6) ? 4'b1010 : 4'b0000);
            end
        end
        bus.btn_set = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            n_cmp++;
            if (bus.set !== 1'b0) begin
                n_err++;
                $display("FAIL set_release c=%0d got set=%b want 0", c, bus.set);
            end
        end
    endtask

    task automatic test_glitch();
        logic [0:9] pattern;
        pattern = 10'b1110000011;
        for (int c = 0; c < 20; c++) begin
            bus.btn_set = (c < 10) ? pattern[c] : 1'b0;
            step();
            n_cmp++;
            if (bus.set !== 1'b0 || bus.set_count !== 4'b1010) begin
                n_err++;
                $display("FAIL glitch c=%0d got set=%b cnt=%h want 0/a", c, bus.set, bus.set_count);
            end
        end
    endtask

    task automatic test_dec();
        for (int p = 0; p < 2; p++) begin
            bus.btn_dec = 1'b1;
            for (int c = 0; c < 12; c++) begin
                logic want;
                want = (p == 0) ? (c >= 6) : (c < 6);
                step();
                n_cmp++;
                if (bus.dec !== want || bus.set !== 1'b0) begin
                    n_err++;
                    $display("FAIL dec_press p=%0d c=%0d got dec=%b set=%b want %b/0", p, c, bus.dec, bus.set, want);
                end
            end
            bus.btn_dec = 1'b0;
            for (int c = 0; c < 10; c++) begin
                step();
                n_cmp++;
                if (bus.dec !== ((p == 0) ? 1'b1 : 1'b0)) begin
                    n_err++;
                    $display("FAIL dec_release p=%0d c=%0d got %b want %b", p, c, bus.dec, (p == 0) ? 1'b1 : 1'b0);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        bus.sw      = 4'h7;
        bus.btn_set = 1'b1;
        bus.btn_dec = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            n_cmp++;
            if (bus.set !== exp_pulse(c) || bus.dec !== (c >= 6)) begin
                n_err++;
                $display("FAIL simul c=%0d got set=%b dec=%b want %b/%b", c, bus.set, bus.dec, exp_pulse(c), (c >= 6));
            end
            n_cmp++;
            if (bus.set_count !== ((c >= 6) ? 4'h7 : 4'ha)) begin
                n_err++;
                $display("FAIL simul_cnt c=%0d got %h want %h", c, bus.set_count, (c >= 6) ? 4'h7 : 4'ha);
            end
        end
        bus.btn_set = 1'b0;
        bus.btn_dec = 1'b0;
        for (int c = 0; c < 10; c++) step();
    endtask

    task automatic test_reset_mid();
        bus.sw      = 4'h5;
        bus.btn_set = 1'b1;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if ({bus.set, bus.dec, bus.set_count} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_mid_state got set=%b dec=%b cnt=%h want 0/0/0", bus.set, bus.dec, bus.set_count);
        end
        reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            n_cmp++;
            if (bus.set !== exp_pulse(c) || bus.dec !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid c=%0d got set=%b dec=%b want %b/0", c, bus.set, bus.dec, exp_pulse(c));
            end
            n_cmp++;
            if (bus.set_count !== ((c >= 6) ? 4'h5 : 4'h0)) begin
                n_err++;
                $display("FAIL reset_mid_cnt c=%0d got %h want %h", c, bus.set_count, (c >= 6) ? 4'h5 : 4'h0);
            end
        end
        bus.btn_set = 1'b0;
        for (int c = 0; c < 10; c++) step();
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b1;
        bus.btn_set = 1'b0;
        bus.btn_dec = 1'b0;
        bus.sw      = 4'h0;
        #2;
        test_reset();
        test_set_press();
        test_glitch();
        test_dec();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_cond.md
Name: key_cond

Overview:
Input conditioner that sits directly upstream of the 4-bit up/down counter and drives its set, set_count and dec inputs from raw board buttons and switches. It synchronises, debounces and edge-detects two push-buttons and one switch bank. It produces a one-cycle set pulse with a latched load value, and a dec level that toggles on each debounced press.

Parameters:
DEB_CYCLES, 4, consecutive synchronised cycles an input must differ from its debounced state before that state flips (min 2)
SW_W, 4, switch-bank and set_count width
REPEAT_CYCLES, 32, auto-repeat period in cycles (used only with KEY_COND_AUTO_REPEAT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous reset, active-high
btn_set  in  1  raw load button, asynchronous, active-high, may bounce
btn_dec  in  1  raw direction button, asynchronous, active-high, may bounce
sw  in  SW_W  raw switch bank, asynchronous
set  out  1  one-cycle load pulse to the counter
set_count  out  SW_W  load value, registered, held between loads
dec  out  1  count-direction level, 0 = up, 1 = down

Behaviour:
- Reset: when reset=1 at a clk edge, clear all synchroniser flops, debounce counters, debounced states, set, set_count and dec to 0. Reset overrides all other activity, including mid-debounce and mid-pulse.
- Synchronisation: btn_set, btn_dec and each sw bit pass through a 2-flop synchroniser (s1 then s2).
- Debounce, per button, with counter width ceil(log2(DEB_CYCLES)):
  - If s2 equals the debounced state, clear the counter.
  - Otherwise increment the counter. On the edge where the counter equals DEB_CYCLES-1 and s2 still differs, flip the debounced state and clear the counter.
  - Any return of s2 to the debounced state before that edge discards the count, so glitches shorter than DEB_CYCLES cycles are ignored.
- Press: a 0->1 transition of the debounced state, detected against a one-cycle-delayed copy. Releases (1->0) are debounced identically but generate no event.
- set: registered, high for exactly one cycle per btn_set press.
  - Latency: if btn_set is sampled high at edge E and stays high, set is 1 after edge E+DEB_CYCLES+2 and 0 after edge E+DEB_CYCLES+3.
- set_count: on the same edge that raises set, load it from the synchronised sw (s2). Otherwise it holds. It is valid whenever set=1.
- dec: toggles on the edge corresponding to a btn_dec press, with the same latency as set. It holds otherwise.
- Simultaneous presses: both act in the same cycle (set pulses and dec toggles). The counter gives set priority.
- Held button: with the feature off, a held button produces exactly one event. A new event needs a debounced release followed by a debounced press.
- sw changes alone never produce an event.

Optional Feature:
KEY_COND_AUTO_REPEAT_EN
- Defined: while the debounced btn_set stays 1, a repeat counter restarts at each press and emits a further set pulse every REPEAT_CYCLES cycles after the initial pulse. Each repeat pulse reloads set_count from s2. The counter clears on release or reset. dec never repeats.
- Undefined: no repeat logic and no REPEAT_CYCLES counter are built; a held button gives exactly one set pulse.

Test Plan:
- Reset, then idle 20 cycles -> set=0, dec=0, set_count=0 throughout.
- sw=4'b1010; btn_set high from edge 0 and held 40 cycles (DEB_CYCLES=4, feature off) -> set=1 only after edge 6; set_count=4'b1010 from edge 6; no further pulses.
- btn_set glitches high for 3 cycles, low 5, high 2 -> no set pulse, set_count unchanged.
- Two debounced btn_dec presses separated by a 10-cycle release -> dec 0->1 after the first press's edge+6, then 1->0 after the second.
- btn_set and btn_dec rise on the same edge, sw=4'h7 -> set pulse and dec toggle in the same cycle, set_count=4'h7.
- reset asserted 3 cycles into a btn_set debounce, btn_set held -> all outputs 0. After reset releases, a full DEB_CYCLES+2 latency is measured from the next high sample; exactly one pulse. With KEY_COND_AUTO_REPEAT_EN and REPEAT_CYCLES=8, holding the button instead gives pulses every 8 cycles after the first.
